// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encoding and status-flag bundle
// shared by the pipelined ALU and its combinational core.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROTL = 4'h6,
    OP_ROTR = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic dz;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational evaluation of one ALU op
// (operands + opcode -> result and status flags).
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          sel_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    n;
  logic [SW:0]      n_inv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             dz;

  assign n     = b_i[SW-1:0];
  assign n_inv = (SW+1)'(WIDTH) - {1'b0, n};
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  // extra bit catches the last bit shifted out; n==0 leaves it 0
  assign shl_w = {1'b0, a_i} << n;
  assign shr_w = {a_i, 1'b0} >> n;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    dz    = 1'b0;
    unique case (sel_i)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_MUL: res = a_i * b_i;
      OP_DIV: begin
        dz  = (b_i == '0);
        res = dz ? '1 : a_i / b_i;
      end
      OP_SHL: begin
        res   = shl_w[WIDTH-1:0];
        carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        res   = shr_w[WIDTH:1];
        carry = shr_w[0];
      end
      OP_ROTL: res = (a_i << n) | (a_i >> n_inv);
      OP_ROTR: res = (a_i >> n) | (a_i << n_inv);
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_NAND: res = ~(a_i & b_i);
      OP_XNOR: res = ~(a_i ^ b_i);
      OP_GT:   res = {{(WIDTH-1){1'b0}}, a_i > b_i};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, a_i == b_i};
    endcase
  end

  assign result_o = res;
  assign flags_o  = {carry, res == '0, ovf, dz};

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with status
// flags and a saturating count of consumed results.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_dz,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  alu_op_e          s1_sel_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  alu_flags_t       s2_flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;
  logic             s1_en;
  logic             s2_en;
  logic             out_fire;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign out_fire = s2_valid_q && out_ready;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .sel_i    (s1_sel_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= OP_ADD;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_en)
        s1_valid_q <= in_valid;
      if (s1_en && in_valid) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_sel_q <= alu_op_e'(in_sel);
      end
      if (s2_en)
        s2_valid_q <= s1_valid_q;
      if (s2_en && s1_valid_q) begin
        s2_res_q   <= core_res;
        s2_flags_q <= core_flags;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_carry  = s2_flags_q.carry;
  assign out_zero   = s2_flags_q.zero;
  assign out_ovf    = s2_flags_q.ovf;
  assign out_dz     = s2_flags_q.dz;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random and directed stimulus against an
// arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [W-1:0] r;
    logic c;
    logic z;
    logic v;
    logic dz;
  } exp_t;

  typedef struct packed {
    exp_t e;
    int   cyc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_zero;
  logic          out_ovf;
  logic          out_dz;
  logic [CW-1:0] op_count;

  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   n_acc = 0;
  bit   rr_mode = 0;
  bit   rr_fixed = 1;
  bit   hold = 0;
  exp_t held;
  ent_t q[$];

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_dz     (out_dz),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int a, int b, int sel);
    int m = (1 << W) - 1;
    int h = 1 << (W - 1);
    int n = b % W;
    int r = 0;
    int c = 0;
    int v = 0;
    int d = 0;
    exp_t e;
    case (sel)
      0: begin
        r = a + b; c = (r > m) ? 1 : 0; r = r & m;
        v = (((a ^ b) & h) == 0 && ((r ^ a) & h) != 0) ? 1 : 0;
      end
      1: begin
        r = (a - b) & m; c = (a < b) ? 1 : 0;
        v = (((a ^ b) & h) != 0 && ((r ^ a) & h) != 0) ? 1 : 0;
      end
      2: r = (a * b) & m;
      3: if (b == 0) begin r = m; d = 1; end else r = a / b;
      4: begin
        r = (a << n) & m;
        c = (n != 0) ? ((a >> (W - n)) & 1) : 0;
      end
      5: begin
        r = a >> n;
        c = (n != 0) ? ((a >> (n - 1)) & 1) : 0;
      end
      6: r = ((a << n) | (a >> (W - n))) & m;
      7: r = ((a >> n) | (a << (W - n))) & m;
      8: r = a & b;
      9: r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b) & m;
      12: r = ~(a & b) & m;
      13: r = ~(a ^ b) & m;
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    e.r  = r[W-1:0];
    e.c  = c[0];
    e.z  = (r == 0);
    e.v  = v[0];
    e.dz = d[0];
    return e;
  endfunction

  function automatic exp_t dut_pk();
    exp_t e;
    e.r  = out_result;
    e.c  = out_carry;
    e.z  = out_zero;
    e.v  = out_ovf;
    e.dz = out_dz;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rr_mode ? ($urandom % 4 != 0) : rr_fixed;
    end
  end

  // scoreboard: in-order queue, ages in negedges since accept
  always @(negedge clk) begin
    ent_t en;
    bit   exp_ov;
    bit   exp_ir;
    cyc++;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      hold    = 0;
    end else begin
      exp_ov = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
      exp_ir = !(q.size() == 2 && !out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("op_count", 64'(op_count), 64'(exp_cnt));
      if (hold)
        chk("hold", {out_valid, dut_pk()}, {1'b1, held});
      if (out_valid && q.size() > 0)
        chk("result", 64'(dut_pk()), 64'(q[0].e));
      hold = out_valid && !out_ready;
      held = dut_pk();
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        if (exp_cnt < MAXC) exp_cnt++;
      end
      if (in_valid && in_ready) begin
        en.e   = model(int'(in_a), int'(in_b), int'(in_sel));
        en.cyc = cyc;
        q.push_back(en);
        n_acc++;
      end
    end
  end

  task automatic send(int a, int b, int sel);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_sel   = sel[3:0];
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("send");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   snap;
    int   acc0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sel   = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_result", 64'(dut_pk()), 64'd0);

    chk("pin_add", 64'(model(8'hFF, 8'h01, 0)), {8'h00, 4'b1100});
    chk("pin_xnor", 64'(model(8'hF0, 8'h3C, 13)), {8'h33, 4'b0000});
    chk("pin_sub", 64'(model(8'h80, 8'h01, 1)), {8'h7F, 4'b0010});
    chk("pin_div", 64'(model(8'h10, 8'h00, 3)), {8'hFF, 4'b0001});
    chk("pin_shl", 64'(model(8'h81, 8'h01, 4)), {8'h02, 4'b1000});
    chk("pin_rotr", 64'(model(8'h01, 8'h09, 7)), {8'h80, 4'b0000});

    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hFF, 8'h01, 0);
    send(8'hF0, 8'h3C, 13);
    send(8'h80, 8'h01, 1);
    send(8'h10, 8'h00, 3);
    send(8'h81, 8'h01, 4);
    send(8'h01, 8'h09, 7);
    send(8'h80, 8'h08, 5);
    send(8'h5A, 8'h00, 6);
    drain();

    rr_fixed = 0;
    repeat (2) begin @(posedge clk); #1; end
    snap = exp_cnt;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = W'(8'h10 + i);
      in_b     = W'(8'h03);
      in_sel   = 4'(i);
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_accepted", 64'(n_acc - acc0), 64'd2);
    rr_fixed = 1;
    begin
      int t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) fail_now("stall_release");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("stall_count", 64'(op_count), 64'(snap + 3));
    @(posedge clk);
    #1;

    rr_mode = 1;
    for (int i = 0; i < 800; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rr_mode  = 0;
    rr_fixed = 1;
    drain();

    rr_fixed = 0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a   = W'($urandom);
      in_b   = W'($urandom);
      in_sel = 4'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_op_count", 64'(op_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    rr_fixed = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < MAXC + 5; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 15));
    drain();
    @(negedge clk);
    chk("sat_count", 64'(op_count), 64'(16'hFFFF));
    send(8'h01, 8'h01, 0);
    drain();
    @(negedge clk);
    chk("sat_hold", 64'(op_count), 64'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
